uart_tx_frac: RTL

Parametrised UART transmitter with an input FIFO, a fractional-N baud-tick accumulator, and configurable frame format. It supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. It replaces the fixed 8N1 transmitter and free-running tick counter, and sits between any byte-producing logic (valid/ready source) and the board TX pin.

---
 rtl/uart_tx_frac_if.sv | 10 +
 rtl/uart_tx_frac.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_tx_frac_if.sv
// uart_tx_frac_if: valid/ready word stream feeding the UART transmitter.
interface uart_tx_frac_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    modport master(output tx_data, tx_valid, input tx_ready);
    modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_frac.sv
// uart_tx_frac: FIFO-buffered UART transmitter with a fractional-N baud
// accumulator and configurable data bits, parity and stop bits.
module uart_tx_frac #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int BAUD_INC   = 9,
    parameter int BAUD_MOD   = 3125,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_frac_if.slave               tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        s_out
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int ACW = $clog2(BAUD_MOD + BAUD_INC);
    localparam logic [ACW-1:0] INC    = ACW'(BAUD_INC);
    localparam logic [ACW-1:0] MOD    = ACW'(BAUD_MOD);
    localparam logic [3:0]     LAST_D = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_S = 4'(STOP_BITS - 1);
    localparam logic [AW:0]    FULL   = (AW + 1)'(FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || BAUD_INC <= 0 || BAUD_INC >= BAUD_MOD ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_frac: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [ACW-1:0]       acc_q, acc_d, sum;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [3:0]           bit_q, bit_d;
    logic                 par_q, par_d, s_out_q, s_out_d, push, load, tick;
    state_t               state_q, state_d;

    assign tx.tx_ready = cnt_q != FULL;
    assign push        = tx.tx_valid && tx.tx_ready;
    assign wp_d        = wp_q + AW'(push);
    assign rp_d        = rp_q + AW'(load);
    assign cnt_d       = cnt_q + (AW + 1)'(push) - (AW + 1)'(load);
    assign sum         = acc_q + INC;
    assign tick        = sum >= MOD;
    assign acc_d       = (state_q == IDLE || load) ? '0 : tick ? sum - MOD : sum;
    assign fifo_count  = cnt_q;
    assign busy        = state_q != IDLE || cnt_q != '0;
    assign s_out       = s_out_q;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        par_d   = par_q;
        bit_d   = bit_q;
        load    = 1'b0;
        case (state_q)
            IDLE:  load = cnt_q != '0;
            START: if (tick) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (tick) begin
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 4'd1;
                if (bit_q == LAST_D) begin
                    state_d = (PARITY != 0) ? PAR : STOP;
                    bit_d   = '0;
                end
            end
            PAR: if (tick) begin
                state_d = STOP;
                bit_d   = '0;
            end
            STOP: if (tick) begin
                bit_d = bit_q + 4'd1;
                if (bit_q == LAST_S) begin
                    state_d = IDLE;
                    load    = cnt_q != '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading overrides the stop-tick return to IDLE for back-to-back frames.
        if (load) begin
            state_d = START;
            sh_d    = mem[rp_q];
            par_d   = (PARITY == 1) ^ (^mem[rp_q]);
            bit_d   = '0;
        end
        s_out_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PAR ? par_d : 1'b1;
    end

    always_ff @(posedge clk)
        if (push) mem[wp_q] <= tx.tx_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            s_out_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            s_out_q <= s_out_d;
        end
endmodule
